serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/adder_pkg.sv | 10 +
 rtl/serial_adder_chunk.sv | 27 ++
 rtl/serial_adder.sv | 99 +++++++++
 tb/tb_serial_adder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types for the serial adder.
// State encoding of the chunk sequencer.
package adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/serial_adder_chunk.sv
// Combinational CHUNK-bit ripple adder.
// Also exposes the carry into its MSB for overflow detection.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cm
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) |
                    (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[CHUNK];
  assign cm = c[CHUNK-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor, CHUNK bits per clock.
// Operands shift right as slices are consumed, LSB first.
module serial_adder
  import adder_pkg::*;
#(
  parameter int W     = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int N  = W / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [W-1:0]     ar, br, acc, acc_n;
  logic             carry;
  logic [CHUNK-1:0] cs;
  logic             cco, ccm;
  logic             accept, last;

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a (ar[CHUNK-1:0]),
    .b (br[CHUNK-1:0]),
    .ci(carry),
    .s (cs),
    .co(cco),
    .cm(ccm)
  );

  assign busy   = (state == RUN);
  assign accept = !busy && start;
  assign last   = busy && (cnt == CW'(N - 1));
  // New slice enters at the top; after N slices acc holds the full result.
  assign acc_n  = W'({cs, acc} >> CHUNK);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      ar    <= '0;
      br    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        ar    <= a;
        br    <= sub ? ~b : b;
        carry <= sub | cin;
        cnt   <= '0;
      end else if (busy) begin
        ar    <= ar >> CHUNK;
        br    <= br >> CHUNK;
        carry <= cco;
        acc   <= acc_n;
        cnt   <= cnt + CW'(1);
        if (last) begin
          cnt  <= '0;
          sum  <= acc_n;
          cout <= cco;
          ovf  <= ccm ^ cco;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder.
// Three configurations: 16/4 directed+random, 4/1 and 4/4 exhaustive.
module tb_serial_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  bit fin [3];

  // Reference: plain integer arithmetic, signed range check for overflow.
  function automatic exp_t model(int w, int av, int bv, bit ci, bit sb);
    exp_t   e;
    longint m = longint'(1) << w;
    longint h = m / 2;
    longint sa, sbv, u, r;
    sa  = (av >= h) ? av - m : av;
    sbv = (bv >= h) ? bv - m : bv;
    if (sb) begin
      u = av - bv + m;
      r = sa - sbv;
    end else begin
      u = av + bv + ci;
      r = sa + sbv + ci;
    end
    e.cout    = (u >= m);
    e.sum     = 16'(u % m);
    e.ovf     = (r >= h) || (r < -h);
    e.acc_cyc = 0;
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int WG = (g == 0) ? 16 : 4;
    localparam int CG = (g == 1) ? 1 : 4;
    localparam int NG = WG / CG;

    logic          rst_n, start, sub, cin;
    logic          busy, done, cout, ovf;
    logic [WG-1:0] a, b, sum;
    exp_t          q[$];
    exp_t          e;
    int            bcnt = 0;
    logic [WG-1:0] last_sum = '0;
    logic          last_c = 1'b0;
    logic          last_o = 1'b0;

    serial_adder #(
      .W(WG),
      .CHUNK(CG)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .sub  (sub),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .busy (busy),
      .done (done),
      .sum  (sum),
      .cout (cout),
      .ovf  (ovf)
    );

    task automatic issue(input int av, input int bv,
                         input bit ci, input bit sb);
      int   guard = 0;
      exp_t x;
      int   am = av & ((1 << WG) - 1);
      int   bm = bv & ((1 << WG) - 1);
      @(negedge clk);
      while (busy && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (busy) begin
        tests++;
        fails++;
        $display("FAIL cfg%0d busy-timeout: busy=%b, required 0", g, busy);
      end
      a     = WG'(am);
      b     = WG'(bm);
      cin   = ci;
      sub   = sb;
      start = 1'b1;
      @(posedge clk);
      x         = model(WG, am, bm, ci, sb);
      x.acc_cyc = cyc;
      q.push_back(x);
      #1 start = 1'b0;
    endtask

    task automatic drain();
      repeat (2 * NG + 4) @(negedge clk);
      tests++;
      if (q.size() != 0) begin
        fails++;
        $display("FAIL cfg%0d drain: %0d results pending, required 0",
                 g, q.size());
      end
      fin[g] = 1'b1;
    endtask

    always @(negedge rst_n) begin
      #1;
      tests++;
      if ({busy, done, cout, ovf, sum} !== '0) begin
        fails++;
        $display("FAIL cfg%0d reset: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                 g, busy, done, sum, cout, ovf);
      end
      last_sum = '0;
      last_c   = 1'b0;
      last_o   = 1'b0;
      bcnt     = 0;
    end

    always @(negedge clk) begin
      if (rst_n === 1'b1) begin
        if (busy) bcnt++;
        tests++;
        if (done) begin
          if (q.size() == 0) begin
            fails++;
            $display("FAIL cfg%0d spurious-done: done=1, required no pending op", g);
          end else begin
            e = q.pop_front();
            if (16'(sum) !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
              fails++;
              $display("FAIL cfg%0d result: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                       g, sum, cout, ovf, e.sum, e.cout, e.ovf);
            end else if (cyc - 1 - e.acc_cyc != NG || bcnt != NG) begin
              fails++;
              $display("FAIL cfg%0d timing: latency=%0d busy_cycles=%0d, required %0d and %0d",
                       g, cyc - 1 - e.acc_cyc, bcnt, NG, NG);
            end
          end
          last_sum = sum;
          last_c   = cout;
          last_o   = ovf;
          bcnt     = 0;
        end else if (sum !== last_sum || cout !== last_c || ovf !== last_o) begin
          fails++;
          $display("FAIL cfg%0d hold: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                   g, sum, cout, ovf, last_sum, last_c, last_o);
        end
      end
    end

    if (g == 0) begin : g_dir
      initial begin
        rst_n = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        #2 rst_n = 1'b0;
        #20;
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(32'hFFFF, 32'h0001, 1'b0, 1'b0);
        issue(32'h7FFF, 32'h0001, 1'b0, 1'b0);
        issue(32'h0005, 32'h0007, 1'b0, 1'b1);
        issue(32'h8000, 32'h0001, 1'b1, 1'b1);
        // Start raised mid-operation must be ignored.
        issue(32'h0F0F, 32'h1111, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a     = 16'h1234;
        b     = 16'h4321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Reset while chunk 2 is being added.
        issue(32'hABCD, 32'h1357, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(32'h1357, 32'h2468, 1'b1, 1'b0);
        repeat (200)
          issue($urandom, $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        drain();
      end
    end else begin : g_exh
      initial begin
        rst_n = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        #2 rst_n = 1'b0;
        #20;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int sb = 0; sb < 2; sb++)
          for (int ci = 0; ci < 2; ci++)
            for (int av = 0; av < 16; av++)
              for (int bv = 0; bv < 16; bv++)
                issue(av, bv, 1'(ci), 1'(sb));
        drain();
      end
    end
  end

  initial begin
    int t = 0;
    while (!(fin[0] && fin[1] && fin[2]) && t < 50000) begin
      @(posedge clk);
      t++;
    end
    if (!(fin[0] && fin[1] && fin[2])) begin
      tests++;
      fails++;
      $display("FAIL global-timeout: finished=%b%b%b, required 111",
               fin[0], fin[1], fin[2]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
